// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: widths, bus-level constants and FSM state encoding.
package i2c_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned CNT_WIDTH  = 3;

  localparam logic ACK         = 1'b0;
  localparam logic NACK        = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_DATA,
    RX_ACK,
    TX_DATA,
    TX_ACK
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the core clock domain and flags SCL edges and START/STOP.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_det_c,
  output logic stop_det_c
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl;
  logic                   scl_d;
  logic                   sda_d;

  // Synchroniser chains plus one delayed copy; idle bus level after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl;
      sda_d    <= sda;
    end
  end

  assign scl = scl_sync[SYNC_STAGES-1];
  assign sda = sda_sync[SYNC_STAGES-1];

  // SDA transitions only count as START/STOP while SCL is steadily high.
  assign scl_rise_c  = scl & ~scl_d;
  assign scl_fall_c  = ~scl & scl_d;
  assign start_det_c = scl & scl_d & sda_d & ~sda;
  assign stop_det_c  = scl & scl_d & ~sda_d & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: address match/ACK, write bytes to RX FIFO, read bytes from TX source.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_WIDTH  = i2c_pkg::DATA_WIDTH
) (
  input  logic                  i2c_core_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] own_address,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_out,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_full,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  busy,
  output logic                  rw
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DATA_WIDTH - 1);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk         (i2c_core_clk),
    .rst_n       (rst_n),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .sda         (sda),
    .scl_rise_c  (scl_rise),
    .scl_fall_c  (scl_fall),
    .start_det_c (start_det),
    .stop_det_c  (stop_det)
  );

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  last, last_nxt;
  logic                  nack_pend, nack_pend_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  sda_out_nxt, rx_valid_nxt, tx_ready_nxt, tx_underrun_nxt;
  logic                  busy_nxt, rw_nxt;
  logic [DATA_WIDTH-1:0] rx_data_nxt;
  logic                  tx_load;

  // State and registered outputs; async reset releases SDA immediately.
  always_ff @(posedge i2c_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= CNT_MAX;
      last        <= 1'b0;
      nack_pend   <= 1'b0;
      shreg       <= '0;
      sda_out     <= 1'b1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      rw          <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      nack_pend   <= nack_pend_nxt;
      shreg       <= shreg_nxt;
      sda_out     <= sda_out_nxt;
      rx_data     <= rx_data_nxt;
      rx_valid    <= rx_valid_nxt;
      tx_ready    <= tx_ready_nxt;
      tx_underrun <= tx_underrun_nxt;
      busy        <= busy_nxt;
      rw          <= rw_nxt;
    end
  end

  // Next-state logic; STOP beats START beats per-bit data actions.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    last_nxt        = last;
    nack_pend_nxt   = nack_pend;
    shreg_nxt       = shreg;
    sda_out_nxt     = sda_out;
    rx_data_nxt     = rx_data;
    rx_valid_nxt    = 1'b0;
    tx_ready_nxt    = 1'b0;
    tx_underrun_nxt = 1'b0;
    busy_nxt        = busy;
    rw_nxt          = rw;
    tx_load         = 1'b0;

    if (stop_det) begin
      state_nxt     = IDLE;
      sda_out_nxt   = 1'b1;
      busy_nxt      = 1'b0;
      nack_pend_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt     = ADDR;
      cnt_nxt       = CNT_MAX;
      last_nxt      = 1'b0;
      sda_out_nxt   = 1'b1;
      busy_nxt      = 1'b0;
      nack_pend_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: sda_out_nxt = 1'b1;
        ADDR, RX_DATA: begin
          if (scl_rise) begin
            shreg_nxt = {shreg[DATA_WIDTH-2:0], sda};
            if (cnt == '0) last_nxt = 1'b1;
            else           cnt_nxt  = cnt - CNT_WIDTH'(1);
          end else if (scl_fall && last) begin
            if (state == ADDR) begin
              if (enable && (shreg[DATA_WIDTH-1:1] == own_address)) begin
                state_nxt   = ADDR_ACK;
                sda_out_nxt = ACK;
                busy_nxt    = 1'b1;
                rw_nxt      = shreg[0];
              end else begin
                state_nxt   = IDLE;
                sda_out_nxt = 1'b1;
              end
            end else begin
              state_nxt = RX_ACK;
              if (rx_full) begin
                sda_out_nxt   = NACK;
                nack_pend_nxt = 1'b1;
              end else begin
                sda_out_nxt  = ACK;
                rx_valid_nxt = 1'b1;
                rx_data_nxt  = shreg;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw == I2C_RW_READ) begin
              tx_load = 1'b1;
            end else begin
              state_nxt   = RX_DATA;
              cnt_nxt     = CNT_MAX;
              last_nxt    = 1'b0;
              sda_out_nxt = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_out_nxt = 1'b1;
            if (nack_pend) begin
              state_nxt     = IDLE;
              busy_nxt      = 1'b0;
              nack_pend_nxt = 1'b0;
            end else begin
              state_nxt = RX_DATA;
              cnt_nxt   = CNT_MAX;
              last_nxt  = 1'b0;
            end
          end
        end
        TX_DATA: begin
          if (scl_fall) begin
            if (cnt == '0) begin
              state_nxt   = TX_ACK;
              sda_out_nxt = 1'b1;
            end else begin
              shreg_nxt   = {shreg[DATA_WIDTH-2:0], 1'b0};
              sda_out_nxt = shreg[DATA_WIDTH-2];
              cnt_nxt     = cnt - CNT_WIDTH'(1);
            end
          end
        end
        TX_ACK: begin
          if (scl_rise && (sda == NACK)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else if (scl_fall) begin
            tx_load = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // Fetch the next read byte and drive its MSB straight away.
      if (tx_load) begin
        state_nxt = TX_DATA;
        cnt_nxt   = CNT_MAX;
        if (tx_valid) begin
          shreg_nxt    = tx_data;
          sda_out_nxt  = tx_data[DATA_WIDTH-1];
          tx_ready_nxt = 1'b1;
        end else begin
          shreg_nxt       = {DATA_WIDTH{1'b1}};
          sda_out_nxt     = 1'b1;
          tx_underrun_nxt = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench: bit-banged I2C master against i2c_target on a wired-AND SDA line.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [6:0] own_address = 7'h6B;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_full = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_underrun, busy, rw;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0, txr_cnt = 0, txu_cnt = 0;
  logic [7:0] rx_last = 8'h00;

  assign sda_line = sda_m & sda_out;

  i2c_target dut (
    .i2c_core_clk (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .own_address  (own_address),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_out      (sda_out),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_full      (rx_full),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_underrun  (tx_underrun),
    .busy         (busy),
    .rw           (rw)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-cycle handshake outputs.
  always @(posedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_last = rx_data;
    end
    if (tx_ready)    txr_cnt = txr_cnt + 1;
    if (tx_underrun) txu_cnt = txu_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    sda_m = b;
    wq();
    scl_m = 1'b1;
    wq();
    r = sda_line;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wq();
    if (!scl_m) begin
      scl_m = 1'b1;
      wq();
    end
    sda_m = 1'b0;
    wq();
    scl_m = 1'b0;
    wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wq();
    scl_m = 1'b1;
    wq();
    sda_m = 1'b1;
    wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], r);
    bit_cycle(1'b1, ack);
  endtask

  task automatic read_bits(output logic [7:0] d);
    logic r;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b1, r);
      d = {d[6:0], r};
    end
  endtask

  initial begin
    logic       ack, r;
    logic [7:0] d;
    int         rx0, txr0, txu0;

    repeat (5) @(negedge clk);
    check("rst_sda_out", sda_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rw", rw, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_tx_underrun", tx_underrun, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xAA to address 0x6B.
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hD6, ack);
    check("wr_addr_ack", ack, ACK);
    check("wr_busy", busy, 1'b1);
    check("wr_rw", rw, 1'b0);
    send_byte(8'hAA, ack);
    check("wr_data_ack", ack, ACK);
    i2c_stop();
    wq();
    check("wr_rx_count", rx_cnt - rx0, 1);
    check("wr_rx_data", rx_last, 8'hAA);
    check("wr_busy_after_stop", busy, 1'b0);

    // Read 0x5C then an underrun 0xFF, master NACKs the second byte.
    txr0 = txr_cnt;
    txu0 = txu_cnt;
    tx_data  = 8'h5C;
    tx_valid = 1'b1;
    i2c_start();
    send_byte(8'hD7, ack);
    check("rd_addr_ack", ack, ACK);
    check("rd_rw", rw, 1'b1);
    read_bits(d);
    check("rd_byte0", d, 8'h5C);
    tx_valid = 1'b0;
    bit_cycle(ACK, r);
    read_bits(d);
    check("rd_byte1", d, 8'hFF);
    bit_cycle(NACK, r);
    check("rd_busy_after_nack", busy, 1'b0);
    check("rd_sda_released", sda_out, 1'b1);
    i2c_stop();
    check("rd_tx_ready_count", txr_cnt - txr0, 1);
    check("rd_tx_underrun_count", txu_cnt - txu0, 1);

    // Wrong address, then right address with the target disabled.
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hA0, ack);
    check("mis_addr_nack", ack, NACK);
    check("mis_busy", busy, 1'b0);
    i2c_stop();
    enable = 1'b0;
    i2c_start();
    send_byte(8'hD6, ack);
    check("dis_addr_nack", ack, NACK);
    check("dis_busy", busy, 1'b0);
    i2c_stop();
    enable = 1'b1;
    check("mis_rx_count", rx_cnt - rx0, 0);

    // RX FIFO full: data byte is NACKed and the target drops off the bus.
    rx0 = rx_cnt;
    rx_full = 1'b1;
    i2c_start();
    send_byte(8'hD6, ack);
    check("full_addr_ack", ack, ACK);
    send_byte(8'h11, ack);
    check("full_data_nack", ack, NACK);
    check("full_busy", busy, 1'b0);
    i2c_stop();
    rx_full = 1'b0;
    check("full_rx_count", rx_cnt - rx0, 0);

    // Repeated START after four data bits, then a read address.
    rx0 = rx_cnt;
    txr0 = txr_cnt;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    i2c_start();
    send_byte(8'hD6, ack);
    check("rs_addr0_ack", ack, ACK);
    bit_cycle(1'b1, r);
    bit_cycle(1'b0, r);
    bit_cycle(1'b1, r);
    bit_cycle(1'b0, r);
    i2c_start();
    send_byte(8'hD7, ack);
    check("rs_addr1_ack", ack, ACK);
    check("rs_rw", rw, 1'b1);
    check("rs_busy", busy, 1'b1);
    check("rs_tx_ready", txr_cnt - txr0, 1);
    read_bits(d);
    check("rs_byte", d, 8'hA5);
    bit_cycle(NACK, r);
    i2c_stop();
    tx_valid = 1'b0;
    check("rs_rx_count", rx_cnt - rx0, 0);

    // Reset while the address ACK is being driven, then a clean write.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      d = 8'hD6;
      bit_cycle(d[i], r);
    end
    check("rr_ack_driven", sda_out, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rr_sda_async", sda_out, 1'b1);
    check("rr_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bit_cycle(1'b1, r);
    i2c_stop();
    rx0 = rx_cnt;
    i2c_start();
    send_byte(8'hD6, ack);
    check("rr_addr_ack", ack, ACK);
    send_byte(8'h33, ack);
    check("rr_data_ack", ack, ACK);
    i2c_stop();
    wq();
    check("rr_rx_count", rx_cnt - rx0, 1);
    check("rr_rx_data", rx_last, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder; the far end of the bus from the existing I2C master controller.
- Oversamples SCL/SDA on i2c_core_clk, detects START/STOP, matches a 7-bit address and ACKs it.
- Write transfers: received bytes go to the RX FIFO.
- Read transfers: bytes are pulled from the TX source and shifted out. Sits behind the APB register block beside the master.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the scl_in/sda_in synchronisers (min 2).
- DATA_WIDTH, 8, byte width. Fixed at 8 for I2C; kept as a parameter only for the shared package.

Ports:
- i2c_core_clk  in  1  core clock; must be at least 8x the SCL rate.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  target enable. When 0, no address is ever ACKed.
- own_address  in  7  target address; sampled when an address byte completes.
- scl_in  in  1  bus SCL, asynchronous.
- sda_in  in  1  bus SDA, asynchronous.
- sda_out  out  1  open-drain SDA control: 0 = pull low, 1 = release.
- rx_data  out  8  last received write byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid.
- rx_full  in  1  RX FIFO full; the byte in progress is NACKed.
- tx_data  in  8  next read byte.
- tx_valid  in  1  tx_data is available.
- tx_ready  out  1  one-cycle pulse; tx_data consumed this cycle.
- tx_underrun  out  1  one-cycle pulse; 0xFF sent because tx_valid was 0.
- busy  out  1  high from an address match until STOP, NACK or abort.
- rw  out  1  R/W bit of the current matched transfer.

Behaviour:
- Reset, async: sda_out=1, rx_data=0, rx_valid=0, tx_ready=0, tx_underrun=0, busy=0, rw=0, state=IDLE, bit counter=7. Sync flops reset to 1.
- Edge detection works on synchronised signals plus one delayed copy, all on i2c_core_clk:
  - SCL rise/fall = 0->1 / 1->0 transition.
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
- Bit timing:
  - SDA is sampled at an SCL rise.
  - sda_out changes only on the cycle after an SCL fall.
- States and transitions:
  - IDLE: sda_out=1. START -> ADDR with counter=7.
  - ADDR: shift sda MSB first on each SCL rise; counter decrements.
    - After bit 0 (R/W) has been shifted, at the next SCL fall: if enable=1 and addr[7:1]==own_address, go to ADDR_ACK, set busy=1 and latch rw. Otherwise go to IDLE with sda_out released.
  - ADDR_ACK: sda_out=0 for one SCL period. At the SCL fall ending it: rw=0 -> RX_DATA; rw=1 -> TX_DATA, which loads the shifter and drives bit 7 immediately.
  - RX_DATA: shift 8 bits. At the SCL fall after bit 0:
    - rx_full=0: pulse rx_valid with rx_data = byte, then RX_ACK with sda_out=0.
    - rx_full=1: no pulse, RX_ACK with sda_out=1 (NACK), then IDLE after that ACK clock.
  - RX_ACK: at the SCL fall go to RX_DATA, counter=7, sda_out=1.
  - TX_DATA: on entry, if tx_valid=1 load tx_data and pulse tx_ready; else load 0xFF and pulse tx_underrun. Present one bit per SCL fall, MSB first. After bit 0's SCL fall -> TX_ACK with sda_out=1.
  - TX_ACK: sample SDA at the SCL rise.
    - 0 (master ACK): at the SCL fall go to TX_DATA with a new load.
    - 1 (master NACK): go to IDLE, busy=0.
- Priority of bus conditions:
  - STOP in any state -> IDLE, sda_out=1, busy=0, no rx_valid for a partial byte.
  - Repeated START in any state -> ADDR, counter=7, partial byte discarded.
  - A START/STOP in the same cycle as an SCL edge takes priority over the data action.
- Latency: rx_valid is 1-2 core cycles after the SCL fall ending bit 0; tx_ready is in the cycle TX_DATA is entered.
- Clock stretching is not supported; scl is input only.
- Reset asserted mid-transfer: sda_out released within the same cycle (asynchronous path); the bus recovers at the next START.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK;
  - DATA_WIDTH;
  - the ACK=0 / NACK=1 constants;
  - the I2C_RW_READ=1 constant.
- One sub-module, i2c_bus_sync: synchroniser, delayed copy, and scl_rise/scl_fall/start_det/stop_det pulses.

Test Plan:
- Write: own_address=7'h6B; master sends START, 0xD6, 0xAA, STOP -> ACK on address and data; rx_valid pulses once with rx_data=0xAA; busy=0 after STOP.
- Read: master sends 0xD7; tx_data=0x5C, tx_valid=1; master ACKs, then sends a second byte with tx_valid=0, master NACKs -> SDA carries 0x5C then 0xFF; tx_ready pulses once, tx_underrun once; returns to IDLE.
- Address mismatch: 0xA0 sent, or enable=0 with 0xD6 -> sda_out stays 1 through the 9th clock; busy=0; no rx_valid.
- Full FIFO: write 0xD6, 0x11 with rx_full=1 -> 9th-bit SDA=1 (NACK), no rx_valid, IDLE afterwards.
- Repeated START after 4 data bits, then 0xD7 -> partial byte dropped, address re-ACKed, rw=1, TX_DATA entered.
- Reset asserted while sda_out=0 in ADDR_ACK -> sda_out=1 immediately, busy=0; a following clean write of 0xD6, 0x33 is received correctly.
